// File: rtl/approx_adder_error_sweep_if.sv
// approx_adder_error_sweep_if: operand/result bus between the sweeper and the adder under test
interface approx_adder_error_sweep_if;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;

    modport master (output add_a, output add_b, output add_cin, input add_sum, input add_cout);
    modport slave  (input add_a, input add_b, input add_cin, output add_sum, output add_cout);
endinterface

// File: rtl/approx_adder_error_sweep.sv
// approx_adder_error_sweep: sweeps an operand rectangle through an external adder and gathers error-distance statistics
module approx_adder_error_sweep (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [7:0]                        a_lo,
    input  logic [7:0]                        a_hi,
    input  logic [7:0]                        b_lo,
    input  logic [7:0]                        b_hi,
    approx_adder_error_sweep_if.master        bus,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err,
    output logic [16:0]                       pair_count,
    output logic [16:0]                       err_count,
    output logic [8:0]                        max_ed,
    output logic [24:0]                       sum_ed,
    output logic                              first_err_valid,
    output logic [7:0]                        first_err_a,
    output logic [7:0]                        first_err_b
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] a_hi_q;
    logic [7:0] b_lo_q;
    logic [7:0] b_hi_q;
    logic       bad_cfg;
    logic       b_wrap;
    logic       last;
    logic [8:0] exact;
    logic [8:0] approx;
    logic [8:0] ed;

    assign bad_cfg     = (a_lo > a_hi) || (b_lo > b_hi);
    assign exact       = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    assign approx      = {bus.add_cout, bus.add_sum};
    assign ed          = (exact >= approx) ? exact - approx : approx - exact;
    // the last pair is detected by equality so ranges ending at 255 never wrap
    assign b_wrap      = bus.add_b == b_hi_q;
    assign last        = b_wrap && (bus.add_a == a_hi_q);
    assign bus.add_cin = 1'b0;

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next-state: invalid ranges skip RUN; the final pair or an abort ends the sweep
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? (bad_cfg ? DONE : RUN) : IDLE;
            RUN:     state_next = (abort || last) ? DONE : RUN;
            default: state_next = IDLE;
        endcase
    end

    // status outputs decoded from state
    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    // operand stepping and statistics accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            a_hi_q          <= '0;
            b_lo_q          <= '0;
            b_hi_q          <= '0;
            bus.add_a       <= '0;
            bus.add_b       <= '0;
            cfg_err         <= 1'b0;
            pair_count      <= '0;
            err_count       <= '0;
            max_ed          <= '0;
            sum_ed          <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
        end else if (state == IDLE && start) begin
            a_hi_q          <= a_hi;
            b_lo_q          <= b_lo;
            b_hi_q          <= b_hi;
            cfg_err         <= bad_cfg;
            pair_count      <= '0;
            err_count       <= '0;
            max_ed          <= '0;
            sum_ed          <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            if (!bad_cfg) begin
                bus.add_a <= a_lo;
                bus.add_b <= b_lo;
            end
        end else if (state == RUN) begin
            pair_count <= pair_count + 17'd1;
            if (ed != 9'd0) begin
                err_count <= err_count + 17'd1;
                sum_ed    <= sum_ed + {16'd0, ed};
                if (ed > max_ed)
                    max_ed <= ed;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_a     <= bus.add_a;
                    first_err_b     <= bus.add_b;
                end
            end
            if (!last && !abort) begin
                if (b_wrap) begin
                    bus.add_b <= b_lo_q;
                    bus.add_a <= bus.add_a + 8'd1;
                end else begin
                    bus.add_b <= bus.add_b + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_approx_adder_error_sweep.sv
// tb_approx_adder_error_sweep: directed checks of the sweeper against simple adder stubs
module tb_approx_adder_error_sweep;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  a_lo, a_hi, b_lo, b_hi;
    logic        busy, done, cfg_err;
    logic [16:0] pair_count, err_count;
    logic [8:0]  max_ed;
    logic [24:0] sum_ed;
    logic        first_err_valid;
    logic [7:0]  first_err_a, first_err_b;
    logic [1:0]  mode;
    logic [8:0]  stub_exact;
    int          n_cmp = 0;
    int          n_bad = 0;

    approx_adder_error_sweep_if bus();

    // mode 0: exact adder, 1: sum bit0 stuck at 0, 2: always zero
    assign stub_exact = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    assign {bus.add_cout, bus.add_sum} = (mode == 2'd0) ? stub_exact :
                                         (mode == 2'd1) ? (stub_exact & 9'h1FE) : 9'd0;

    approx_adder_error_sweep dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_lo(a_lo), .a_hi(a_hi), .b_lo(b_lo), .b_hi(b_hi),
        .bus(bus),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .pair_count(pair_count), .err_count(err_count),
        .max_ed(max_ed), .sum_ed(sum_ed),
        .first_err_valid(first_err_valid),
        .first_err_a(first_err_a), .first_err_b(first_err_b)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] al, input logic [7:0] ah, input logic [7:0] bl, input logic [7:0] bh);
        a_lo = al; a_hi = ah; b_lo = bl; b_hi = bh;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (!done && cyc < limit) begin
            tick;
            cyc++;
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({busy, done, cfg_err, first_err_valid, bus.add_cin} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags got %b want 00000", {busy, done, cfg_err, first_err_valid, bus.add_cin});
        end
        n_cmp++;
        if ({bus.add_a, bus.add_b, first_err_a, first_err_b} !== 32'd0) begin
            n_bad++; $display("FAIL reset_operands got %h want 0", {bus.add_a, bus.add_b, first_err_a, first_err_b});
        end
        n_cmp++;
        if ({pair_count, err_count, max_ed, sum_ed} !== 68'd0) begin
            n_bad++; $display("FAIL reset_stats got %h want 0", {pair_count, err_count, max_ed, sum_ed});
        end
        rst = 1'b0;
        tick;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL reset_idle got %b want 00", {busy, done});
        end
    endtask

    task automatic test_single_pair;
        int cyc;
        mode = 2'd0;
        launch(8'd65, 8'd65, 8'd76, 8'd76);
        n_cmp++;
        if (busy !== 1'b1 || bus.add_a !== 8'd65 || bus.add_b !== 8'd76) begin
            n_bad++; $display("FAIL single_run got busy=%b a=%0d b=%0d want busy=1 a=65 b=76", busy, bus.add_a, bus.add_b);
        end
        wait_done(10, cyc);
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++; $display("FAIL single_latency got %0d want 2", cyc);
        end
        n_cmp++;
        if (pair_count !== 17'd1 || err_count !== 17'd0 || max_ed !== 9'd0 || sum_ed !== 25'd0) begin
            n_bad++; $display("FAIL single_stats got pc=%0d ec=%0d max=%0d sum=%0d want 1 0 0 0", pair_count, err_count, max_ed, sum_ed);
        end
        tick;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL single_done_pulse got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_lsb_error;
        int cyc;
        mode = 2'd1;
        launch(8'd0, 8'd3, 8'd0, 8'd3);
        wait_done(40, cyc);
        n_cmp++;
        if (cyc !== 17) begin
            n_bad++; $display("FAIL lsb_latency got %0d want 17", cyc);
        end
        n_cmp++;
        if (pair_count !== 17'd16 || err_count !== 17'd8 || max_ed !== 9'd1 || sum_ed !== 25'd8) begin
            n_bad++; $display("FAIL lsb_stats got pc=%0d ec=%0d max=%0d sum=%0d want 16 8 1 8", pair_count, err_count, max_ed, sum_ed);
        end
        n_cmp++;
        if (first_err_valid !== 1'b1 || first_err_a !== 8'd0 || first_err_b !== 8'd1) begin
            n_bad++; $display("FAIL lsb_first got v=%b a=%0d b=%0d want 1 0 1", first_err_valid, first_err_a, first_err_b);
        end
        tick;
    endtask

    task automatic test_zero_stub;
        int cyc;
        mode = 2'd2;
        launch(8'd255, 8'd255, 8'd255, 8'd255);
        wait_done(10, cyc);
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++; $display("FAIL zero_latency got %0d want 2", cyc);
        end
        n_cmp++;
        if (pair_count !== 17'd1 || err_count !== 17'd1 || max_ed !== 9'd510 || sum_ed !== 25'd510) begin
            n_bad++; $display("FAIL zero_stats got pc=%0d ec=%0d max=%0d sum=%0d want 1 1 510 510", pair_count, err_count, max_ed, sum_ed);
        end
        n_cmp++;
        if (first_err_a !== 8'd255 || first_err_b !== 8'd255 || bus.add_a !== 8'd255 || bus.add_b !== 8'd255) begin
            n_bad++; $display("FAIL zero_nowrap got fa=%0d fb=%0d a=%0d b=%0d want 255", first_err_a, first_err_b, bus.add_a, bus.add_b);
        end
        tick;
    endtask

    task automatic test_full_sweep;
        int cyc;
        mode = 2'd0;
        launch(8'd0, 8'd255, 8'd0, 8'd255);
        cyc = 1;
        while (!done && cyc < 70000) begin
            start = (cyc == 100 || cyc == 30000);
            tick;
            cyc++;
        end
        start = 1'b0;
        n_cmp++;
        if (cyc !== 65537) begin
            n_bad++; $display("FAIL full_latency got %0d want 65537", cyc);
        end
        n_cmp++;
        if (pair_count !== 17'd65536 || err_count !== 17'd0 || sum_ed !== 25'd0 || first_err_valid !== 1'b0) begin
            n_bad++; $display("FAIL full_stats got pc=%0d ec=%0d sum=%0d fv=%b want 65536 0 0 0", pair_count, err_count, sum_ed, first_err_valid);
        end
        tick;
    endtask

    task automatic test_cfg_err;
        launch(8'd5, 8'd4, 8'd0, 8'd0);
        n_cmp++;
        if ({done, cfg_err, busy} !== 3'b110 || pair_count !== 17'd0) begin
            n_bad++; $display("FAIL cfg_err got done/cfg/busy=%b pc=%0d want 110 0", {done, cfg_err, busy}, pair_count);
        end
        tick;
        n_cmp++;
        if ({done, cfg_err, busy} !== 3'b010) begin
            n_bad++; $display("FAIL cfg_hold got done/cfg/busy=%b want 010", {done, cfg_err, busy});
        end
    endtask

    task automatic test_abort;
        mode = 2'd0;
        launch(8'd0, 8'd255, 8'd0, 8'd255);
        repeat (9) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_cmp++;
        if ({done, busy, cfg_err} !== 3'b100 || pair_count !== 17'd10) begin
            n_bad++; $display("FAIL abort got done/busy/cfg=%b pc=%0d want 100 10", {done, busy, cfg_err}, pair_count);
        end
        tick;
        n_cmp++;
        if ({done, busy} !== 2'b00 || pair_count !== 17'd10) begin
            n_bad++; $display("FAIL abort_hold got done/busy=%b pc=%0d want 00 10", {done, busy}, pair_count);
        end
    endtask

    task automatic test_rst_in_run;
        mode = 2'd1;
        launch(8'd0, 8'd255, 8'd0, 8'd255);
        repeat (9) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++;
        if ({done, busy, first_err_valid} !== 3'b000 || pair_count !== 17'd0 || err_count !== 17'd0 || sum_ed !== 25'd0) begin
            n_bad++; $display("FAIL rst_run got d/b/fv=%b pc=%0d ec=%0d sum=%0d want 000 0 0 0", {done, busy, first_err_valid}, pair_count, err_count, sum_ed);
        end
        tick;
        n_cmp++;
        if ({done, busy} !== 2'b00 || {bus.add_a, bus.add_b} !== 16'd0) begin
            n_bad++; $display("FAIL rst_idle got done/busy=%b a=%0d b=%0d want 00 0 0", {done, busy}, bus.add_a, bus.add_b);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
        a_lo = 8'd0; a_hi = 8'd0; b_lo = 8'd0; b_hi = 8'd0;
        repeat (3) tick;
        test_reset;
        test_single_pair;
        test_lsb_error;
        test_zero_stub;
        test_full_sweep;
        test_cfg_err;
        test_abort;
        test_rst_in_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
